reg_bank_stack: RTL
===================

REG_BANK_STACK -- requirements
Module: reg_bank_stack

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and link data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width, giving NREGS = 2**ADDR_W registers.
REQ-003 SHALL have parameter LINK_DEPTH, default 4 (min 2), link-stack entries.
REQ-004 SHALL have parameter HARD_ZERO, default 0; 1 makes register 0 constant zero.
REQ-005 SHALL have the following ports, in this order:
- clock  in  1  sole clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rh_addr, ro_addr, rd_addr  in  ADDR_W  three read-port addresses.
- wr_en  in  1  register write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- link_push  in  1  push link_data onto the link stack.
- link_pop  in  1  pop the link stack.
- link_data  in  DATA_W  value to push.
- rh_value, ro_value, rd_value  out  DATA_W  read data.
- link_value  out  DATA_W  top-of-stack value.
- link_count  out  $clog2(LINK_DEPTH+1)  number of valid entries.
- link_empty, link_full  out  1  count==0 / count==LINK_DEPTH.
- link_err  out  1  registered one-cycle overflow/underflow pulse.

Function
REQ-006 SHALL write wr_data to register wr_addr on the rising edge when wr_en=1.
REQ-007 SHALL drive all three reads combinationally from current contents; the three ports are independent and any addresses may coincide.
REQ-008 With HARD_ZERO=1, SHALL ignore writes to address 0 and SHALL return 0 for reads of address 0, including under bypass.
REQ-009 SHALL drive link_value from the top entry when link_count>0, otherwise 0.
REQ-010 push only, count<LINK_DEPTH: SHALL store link_data as the new top and increment count.
REQ-011 push only, full: SHALL discard the oldest entry, store the new top, hold count, and pulse link_err next cycle.
REQ-012 pop only, count>0: SHALL decrement count; the popped value is visible on link_value in the pop cycle.
REQ-013 pop only, empty: SHALL leave state unchanged and pulse link_err.
REQ-014 push+pop, count>0: SHALL replace the top with link_data and hold count; no error.
REQ-015 push+pop, empty: SHALL behave as push only and pulse link_err.
REQ-016 SHALL implement the stack as a circular buffer with a wrapping top pointer (mod LINK_DEPTH); no entry copying.
REQ-017 SHALL clear link_err in every cycle with no error condition.
REQ-018 Register-file and link-stack operations SHALL be fully independent in the same cycle.

Reset
REQ-019 While reset=1 at a rising edge, SHALL zero all NREGS registers, empty the stack (count 0, pointer 0), and clear link_err.
REQ-020 reset SHALL take priority over wr_en, link_push and link_pop in the same cycle; none of them takes effect.
REQ-021 After reset: read outputs, link_value and link_count SHALL be 0, link_empty=1 and link_full=0.

Configuration
REQ-022 With macro REG_BANK_STACK_BYPASS_EN defined, any read port whose address equals wr_addr while wr_en=1 SHALL return wr_data in that same cycle, subject to REQ-008.
REQ-023 Without REG_BANK_STACK_BYPASS_EN, reads SHALL return pre-edge contents; new data is visible the cycle after the write.

Structure
REQ-024 A shared package SHALL hold the default DATA_W, ADDR_W and LINK_DEPTH constants and the link-stack op-code typedef {NONE, PUSH, POP, REPLACE}.
REQ-025 The link stack SHALL be a sub-module link_stack, parameterised on DATA_W and LINK_DEPTH.

Verification
REQ-026 reset, then read all addresses -> all 0; link_empty=1; link_count=0.
REQ-027 write 0xDEADBEEF to r7, then read r7 on all three ports next cycle -> 0xDEADBEEF on each; with the bypass macro, also in the write cycle.
REQ-028 HARD_ZERO=1: write 0x1234 to r0 -> r0 reads 0; with bypass, r0 still reads 0 in the write cycle.
REQ-029 LINK_DEPTH=4: push 0x10,0x20,0x30,0x40,0x50 -> link_full=1, count=4, link_err pulses once after the 5th push; pops return 0x50,0x40,0x30,0x20; a 5th pop gives link_err and link_value=0.
REQ-030 count=2 with top 0x20: push+pop 0x99 -> count=2, link_value=0x99, no link_err; on empty, push+pop 0x77 -> count=1 and a link_err pulse.
REQ-031 reset asserted together with wr_en (r3=0x5) and link_push -> r3=0, count=0, link_err=0 next cycle.

Source files
------------

// File: rtl/reg_bank_stack_pkg.sv
// Shared defaults and link-stack operation codes for reg_bank_stack.
package reg_bank_stack_pkg;

  localparam int unsigned DEFAULT_DATA_W     = 32;
  localparam int unsigned DEFAULT_ADDR_W     = 5;
  localparam int unsigned DEFAULT_LINK_DEPTH = 4;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PUSH    = 2'd1,
    POP     = 2'd2,
    REPLACE = 2'd3
  } linkOp_t;

endpackage

// File: rtl/reg_bank_stack_link_stack.sv
// Circular-buffer link stack; overflow drops the oldest entry, errors pulse for one cycle.
module link_stack
  import reg_bank_stack_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned LINK_DEPTH = DEFAULT_LINK_DEPTH,
  localparam int unsigned CW        = $clog2(LINK_DEPTH + 1),
  localparam int unsigned PW        = (LINK_DEPTH > 1) ? $clog2(LINK_DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              link_push,
  input  logic              link_pop,
  input  logic [DATA_W-1:0] link_data,
  output logic [DATA_W-1:0] link_value,
  output logic [CW-1:0]     link_count,
  output logic              link_empty,
  output logic              link_full,
  output logic              link_err
);

  logic [DATA_W-1:0] mem [LINK_DEPTH];
  logic [PW-1:0]     nextFree;
  logic [PW-1:0]     topIdx;
  logic [PW-1:0]     incPtr;
  logic [CW-1:0]     count;
  logic              err;
  linkOp_t           op;

  // nextFree is the slot the next push writes; when full it holds the oldest entry.
  assign topIdx = (nextFree == '0) ? PW'(LINK_DEPTH - 1) : nextFree - PW'(1);
  assign incPtr = (nextFree == PW'(LINK_DEPTH - 1)) ? '0 : nextFree + PW'(1);

  always_comb begin
    op = NONE;
    if (link_push && link_pop) op = REPLACE;
    else if (link_push)        op = PUSH;
    else if (link_pop)         op = POP;
  end

  assign link_empty = (count == '0);
  assign link_full  = (count == CW'(LINK_DEPTH));
  assign link_count = count;
  assign link_err   = err;
  assign link_value = link_empty ? '0 : mem[topIdx];

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      nextFree <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (op)
        PUSH: begin
          mem[nextFree] <= link_data;
          nextFree      <= incPtr;
          if (link_full) err <= 1'b1;
          else           count <= count + CW'(1);
        end
        POP: begin
          if (link_empty) begin
            err <= 1'b1;
          end else begin
            nextFree <= topIdx;
            count    <= count - CW'(1);
          end
        end
        REPLACE: begin
          // On an empty stack a replace degenerates into a push and is flagged.
          if (link_empty) begin
            mem[nextFree] <= link_data;
            nextFree      <= incPtr;
            count         <= CW'(1);
            err           <= 1'b1;
          end else begin
            mem[topIdx] <= link_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/reg_bank_stack.sv
// Three-read/one-write register bank plus link stack. Optional same-cycle write
// bypass on the read ports is enabled by defining REG_BANK_STACK_BYPASS_EN.
module reg_bank_stack
  import reg_bank_stack_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned LINK_DEPTH = DEFAULT_LINK_DEPTH,
  parameter int unsigned HARD_ZERO  = 0,
  localparam int unsigned NREGS     = 2 ** ADDR_W,
  localparam int unsigned CW        = $clog2(LINK_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rh_addr,
  input  logic [ADDR_W-1:0] ro_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_push,
  input  logic              link_pop,
  input  logic [DATA_W-1:0] link_data,
  output logic [DATA_W-1:0] rh_value,
  output logic [DATA_W-1:0] ro_value,
  output logic [DATA_W-1:0] rd_value,
  output logic [DATA_W-1:0] link_value,
  output logic [CW-1:0]     link_count,
  output logic              link_empty,
  output logic              link_full,
  output logic              link_err
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [ADDR_W-1:0] rdAddrs [3];
  logic [DATA_W-1:0] rdVals [3];
  logic              zeroLocked;

  assign zeroLocked = (HARD_ZERO != 0) && (wr_addr == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && !zeroLocked) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rdAddrs[0] = rh_addr;
  assign rdAddrs[1] = ro_addr;
  assign rdAddrs[2] = rd_addr;

  // Hard-zero masking is applied last so it also overrides the bypass path.
  always_comb begin
    for (int unsigned p = 0; p < 3; p++) begin
      rdVals[p] = regs[rdAddrs[p]];
`ifdef REG_BANK_STACK_BYPASS_EN
      if (wr_en && (wr_addr == rdAddrs[p])) rdVals[p] = wr_data;
`endif
      if ((HARD_ZERO != 0) && (rdAddrs[p] == '0)) rdVals[p] = '0;
    end
  end

  assign rh_value = rdVals[0];
  assign ro_value = rdVals[1];
  assign rd_value = rdVals[2];

  link_stack #(
    .DATA_W     (DATA_W),
    .LINK_DEPTH (LINK_DEPTH)
  ) linkStack (
    .clock      (clock),
    .reset      (reset),
    .link_push  (link_push),
    .link_pop   (link_pop),
    .link_data  (link_data),
    .link_value (link_value),
    .link_count (link_count),
    .link_empty (link_empty),
    .link_full  (link_full),
    .link_err   (link_err)
  );

endmodule
